// File: rtl/seg_entry_ctrl_pkg.sv
// Shared types, segment encoding and constants for the hex-digit entry controller.
package seg_entry_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD} press_st_t;
    typedef enum logic {MODE_SHIFT, MODE_EDIT} entry_mode_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_SHORT, ACT_LONG} action_t;

    // Active-high segments, bit order {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] seg_drv(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
            4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
            4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
            4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_entry_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for the active-low push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db,
    output logic press,
    output logic rel
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic             sync1, sync2, db_q;
    logic [CNT_W-1:0] cnt;

    // Any sample equal to the current debounced level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            btn_db <= 1'b1;
            db_q   <= 1'b1;
            cnt    <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q  <= btn_db;
            if (sync2 == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                btn_db <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = db_q & ~btn_db;
    assign rel   = ~db_q & btn_db;

endmodule

// File: rtl/seg_entry_ctrl.sv
// Hex-digit entry controller: short/long press decode, SHIFT/EDIT digit entry,
// blinking EDIT cursor and registered 7-segment outputs.
module seg_entry_ctrl
    import seg_entry_ctrl_pkg::*;
#(
    parameter int NUM_SEG      = 6,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int BLINK_CYC    = 12_500_000,
    localparam int CW          = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn,
    input  logic [3:0]           sw,
    input  logic                 mode,
    output logic [7:0]           seg [0:NUM_SEG-1],
    output logic [4*NUM_SEG-1:0] value,
    output logic [CW-1:0]        cursor
);

    localparam int HW = $clog2(LONG_CYC + 1);
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC + 1) : 1;

    logic                     btn_db, press, rel;
    press_st_t                state, state_nxt;
    action_t                  act;
    logic [HW-1:0]            hold_cnt;
    logic [BW-1:0]            blink_cnt;
    logic                     blink_on;
    logic [NUM_SEG-1:0][3:0]  digits;
    entry_mode_t              mode_e;

    assign mode_e = entry_mode_t'(mode);
    assign value  = digits;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (press),
        .rel    (rel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Long is tested before release so a release on the reaching cycle stays long.
    always_comb begin
        state_nxt = state;
        act       = ACT_NONE;
        case (state)
            S_IDLE:  if (press) state_nxt = S_PRESS;
            S_PRESS: begin
                if (hold_cnt == HW'(LONG_CYC)) begin
                    act       = ACT_LONG;
                    state_nxt = btn_db ? S_IDLE : S_HELD;
                end else if (rel) begin
                    act       = ACT_SHORT;
                    state_nxt = S_IDLE;
                end
            end
            S_HELD:  if (btn_db) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != S_PRESS) hold_cnt <= '0;
        else if (hold_cnt != HW'(LONG_CYC)) hold_cnt <= hold_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits <= '0;
            cursor <= '0;
        end else if (act == ACT_LONG) begin
            digits <= '0;
            cursor <= '0;
        end else if (act == ACT_SHORT) begin
            if (mode_e == MODE_EDIT) begin
                digits[cursor] <= sw;
                cursor <= (cursor == CW'(NUM_SEG - 1)) ? '0 : cursor + 1'b1;
            end else begin
                for (int i = NUM_SEG - 1; i > 0; i--) digits[i] <= digits[i-1];
                digits[0] <= sw;
            end
        end
    end

    // Any action restarts the blink visible so a moved cursor shows at once.
    always_ff @(posedge clk) begin
        if (!rst_n || act != ACT_NONE) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEG; i++) begin
            if (!rst_n)
                seg[i] <= seg_drv(4'h0);
            else if (mode_e == MODE_EDIT && cursor == CW'(i) && !blink_on)
                seg[i] <= SEG_BLANK;
            else
                seg[i] <= seg_drv(digits[i]);
        end
    end

endmodule
